// File: rtl/tawas_dbus_pkg.sv
// Shared definitions for the Tawas D-bus responder: region select, register
// word offsets, ERR_STAT field positions and a lane-mask helper.
package tawas_dbus_pkg;

  localparam int REGION_BIT = 30;

  localparam logic [4:0] OFF_ID       = 5'h00;
  localparam logic [4:0] OFF_CYCLE    = 5'h01;
  localparam logic [4:0] OFF_SCRATCH  = 5'h02;
  localparam logic [4:0] OFF_ERR_ADDR = 5'h03;
  localparam logic [4:0] OFF_ERR_STAT = 5'h04;
  localparam logic [4:0] OFF_SEM_BASE = 5'h08;
  localparam logic [4:0] OFF_SEM_MASK = 5'h18;

  localparam int ERR_VALID_BIT = 0;
  localparam int ERR_CNT_LSB   = 4;
  localparam int ERR_CNT_W     = 4;

  // Expands a 4-bit byte-enable into a 32-bit bit mask.
  function automatic logic [31:0] laneMask(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

endpackage

// File: rtl/tawas_dbus_ram.sv
// Single-port data RAM with four byte-write enables and a registered read port.
module tawas_dbus_ram #(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_q;

  // Only one access per cycle, so a load after a store always sees the new data.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tawas_dbus_slave.sv
// Tawas D-bus responder: no-wait data RAM plus register block (ID, cycle
// counter, scratch, error capture, test-and-set semaphores).
module tawas_dbus_slave
  import tawas_dbus_pkg::*;
#(
  parameter int          RAM_AW   = 12,
  parameter logic [31:0] ID_VALUE = 32'h7A3A0001
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DADDR,
  input  logic        DCS,
  input  logic        DWR,
  input  logic [3:0]  DMASK,
  input  logic [31:0] DOUT,
  output logic [31:0] DIN
);

  logic        req, ramSel, outOfRange, ramAcc, ramRd;
  logic        regWr, regRd, semHit, errEv, errClr;
  logic [29:0] highBits;
  logic [4:0]  regOff;
  logic [2:0]  semIdx;
  logic [31:0] wmask, rdVal, ramRdata;

  logic [31:0]          cycle_q, cycle_d;
  logic [31:0]          scratch_q, scratch_d;
  logic [31:0]          errAddr_q, errAddr_d;
  logic                 errValid_q, errValid_d;
  logic [ERR_CNT_W-1:0] errCnt_q, errCnt_d;
  logic [7:0]           sem_q, sem_d;
  logic [31:0]          regData_q;
  logic                 ramLoad_q;

  // Requests seen while reset is high are dropped entirely.
  assign req        = DCS & ~RST;
  assign ramSel     = ~DADDR[REGION_BIT];
  assign highBits   = DADDR[29:0] >> (RAM_AW + 2);
  assign outOfRange = |highBits;
  assign ramAcc     = req & ramSel & ~outOfRange;
  assign ramRd      = ramAcc & ~DWR;
  assign errEv      = req & ramSel & outOfRange;
  assign regOff     = DADDR[6:2];
  assign semIdx     = regOff[2:0];
  assign semHit     = (regOff & OFF_SEM_MASK) == OFF_SEM_BASE;
  assign regWr      = req & ~ramSel & DWR;
  assign regRd      = req & ~ramSel & ~DWR;
  assign errClr     = regWr && regOff == OFF_ERR_STAT && DMASK[0] && DOUT[0];

  tawas_dbus_ram #(.AW(RAM_AW)) u_ram (
    .clk_i   (CLK),
    .en_i    (ramAcc),
    .we_i    (DWR),
    .be_i    (DMASK),
    .addr_i  (DADDR[RAM_AW+1:2]),
    .wdata_i (DOUT),
    .rdata_o (ramRdata)
  );

  always_comb begin
    wmask      = laneMask(DMASK);
    cycle_d    = cycle_q + 32'd1;
    scratch_d  = scratch_q;
    errAddr_d  = errAddr_q;
    errValid_d = errValid_q;
    errCnt_d   = errCnt_q;
    sem_d      = sem_q;
    rdVal      = 32'd0;

    if (regWr && regOff == OFF_CYCLE)   cycle_d   = (cycle_q & ~wmask) | (DOUT & wmask);
    if (regWr && regOff == OFF_SCRATCH) scratch_d = (scratch_q & ~wmask) | (DOUT & wmask);

    if (semHit) begin
      if (regRd) sem_d[semIdx] = 1'b1;
      else if (regWr && DMASK[0]) sem_d[semIdx] = 1'b0;
    end

    // Clear first, then a coincident error re-arms capture from a count of zero.
    if (errClr) begin
      errValid_d = 1'b0;
      errCnt_d   = '0;
    end
    if (errEv) begin
      if (!errValid_d) errAddr_d = DADDR;
      errValid_d = 1'b1;
      if (errCnt_d != {ERR_CNT_W{1'b1}}) errCnt_d = errCnt_d + 1'b1;
    end

    case (regOff)
      OFF_ID:       rdVal = ID_VALUE;
      OFF_CYCLE:    rdVal = cycle_q;
      OFF_SCRATCH:  rdVal = scratch_q;
      OFF_ERR_ADDR: rdVal = errAddr_q;
      OFF_ERR_STAT: begin
        rdVal[ERR_VALID_BIT]                   = errValid_q;
        rdVal[ERR_CNT_LSB +: ERR_CNT_W]        = errCnt_q;
      end
      default:      rdVal = semHit ? {31'd0, sem_q[semIdx]} : 32'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cycle_q    <= '0;
      scratch_q  <= '0;
      errAddr_q  <= '0;
      errValid_q <= 1'b0;
      errCnt_q   <= '0;
      sem_q      <= '0;
      regData_q  <= '0;
      ramLoad_q  <= 1'b0;
    end else begin
      cycle_q    <= cycle_d;
      scratch_q  <= scratch_d;
      errAddr_q  <= errAddr_d;
      errValid_q <= errValid_d;
      errCnt_q   <= errCnt_d;
      sem_q      <= sem_d;
      regData_q  <= regRd ? rdVal : 32'd0;
      ramLoad_q  <= ramRd;
    end
  end

  // regData_q is already zero whenever the previous cycle was not a register load.
  assign DIN = ramLoad_q ? ramRdata : regData_q;

endmodule

// File: tb/tb_tawas_dbus_slave.sv
// Directed bench for tawas_dbus_slave: each bus cycle is driven just after a
// rising edge and DIN is checked 1 ns after the edge that sampled the request.
module tb_tawas_dbus_slave;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] DADDR;
  logic        DCS, DWR;
  logic [3:0]  DMASK;
  logic [31:0] DOUT;
  logic [31:0] DIN;

  int assertCount = 0;
  int failCount   = 0;

  tawas_dbus_slave dut (
    .CLK   (CLK),
    .RST   (RST),
    .DADDR (DADDR),
    .DCS   (DCS),
    .DWR   (DWR),
    .DMASK (DMASK),
    .DOUT  (DOUT),
    .DIN   (DIN)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  // Drives one bus cycle; on return DIN shows the response to this request.
  task automatic applyStimulus(input logic cs, input logic wr, input logic [31:0] addr,
                               input logic [3:0] mask, input logic [31:0] data);
    DCS   = cs;
    DWR   = wr;
    DADDR = addr;
    DMASK = mask;
    DOUT  = data;
    @(posedge CLK);
    #1;
  endtask

  task automatic storeW(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    applyStimulus(1'b1, 1'b1, addr, mask, data);
  endtask

  task automatic loadW(input logic [31:0] addr);
    applyStimulus(1'b1, 1'b0, addr, 4'hF, 32'h0);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  localparam logic [31:0] A_ID      = 32'h4000_0000;
  localparam logic [31:0] A_CYCLE   = 32'h4000_0004;
  localparam logic [31:0] A_SCRATCH = 32'h4000_0008;
  localparam logic [31:0] A_ERRADDR = 32'h4000_000C;
  localparam logic [31:0] A_ERRSTAT = 32'h4000_0010;
  localparam logic [31:0] A_SEM3    = 32'h4000_002C;

  initial begin
    RST = 1'b1;
    idleCycle();
    idleCycle();
    checkOutput("reset_din", DIN, 32'h0);
    RST = 1'b0;

    // RAM basics and lane masking
    storeW(32'h100, 4'hF, 32'h11223344);
    checkOutput("din_after_store", DIN, 32'h0);
    loadW(32'h100);
    checkOutput("ram_load_full", DIN, 32'h11223344);
    idleCycle();
    checkOutput("din_idle", DIN, 32'h0);
    storeW(32'h100, 4'b0100, 32'hAAAAAAAA);
    loadW(32'h100);
    checkOutput("ram_load_lane2", DIN, 32'h11AA3344);
    storeW(32'h104, 4'b0000, 32'h12345678);
    storeW(32'h104, 4'hF, 32'h0BADF00D);
    storeW(32'h104, 4'b0000, 32'hFFFFFFFF);
    loadW(32'h104);
    checkOutput("ram_mask0_noop", DIN, 32'h0BADF00D);

    // Back-to-back store/load and continuous loads
    storeW(32'h200, 4'hF, 32'hDEADBEEF);
    loadW(32'h200);
    checkOutput("b2b_store_load", DIN, 32'hDEADBEEF);
    storeW(32'h0, 4'hF, 32'hA0A0A0A0);
    storeW(32'h4, 4'hF, 32'hA4A4A4A4);
    storeW(32'h8, 4'hF, 32'hA8A8A8A8);
    loadW(32'h0);
    checkOutput("stream_0", DIN, 32'hA0A0A0A0);
    loadW(32'h4);
    checkOutput("stream_4", DIN, 32'hA4A4A4A4);
    loadW(32'h8);
    checkOutput("stream_8", DIN, 32'hA8A8A8A8);

    // Out-of-range accesses (0x4000 aliases word 0 if the range check is broken)
    storeW(32'h0000_4000, 4'hF, 32'h55555555);
    loadW(32'h0);
    checkOutput("oor_ram_unchanged", DIN, 32'hA0A0A0A0);
    loadW(A_ERRADDR);
    checkOutput("err_addr_first", DIN, 32'h0000_4000);
    loadW(A_ERRSTAT);
    checkOutput("err_stat_one", DIN, 32'h11);
    loadW(32'h0000_8004);
    checkOutput("oor_load_zero", DIN, 32'h0);
    storeW(32'h2000_0000, 4'hF, 32'h1);
    loadW(A_ERRSTAT);
    checkOutput("err_stat_three", DIN, 32'h31);
    loadW(A_ERRADDR);
    checkOutput("err_addr_sticky", DIN, 32'h0000_4000);
    storeW(A_ERRSTAT, 4'b0001, 32'h1);
    storeW(32'h0001_0000, 4'hF, 32'h0);
    loadW(A_ERRSTAT);
    checkOutput("err_clear_then_err", DIN, 32'h11);
    loadW(A_ERRADDR);
    checkOutput("err_addr_recapture", DIN, 32'h0001_0000);
    for (int i = 0; i < 20; i++) storeW(32'h0000_4000 + 32'(i * 4), 4'hF, 32'h0);
    loadW(A_ERRSTAT);
    checkOutput("err_cnt_saturate", DIN, 32'hF1);

    // Semaphores
    loadW(A_SEM3);
    checkOutput("sem3_first", DIN, 32'h0);
    loadW(A_SEM3);
    checkOutput("sem3_taken", DIN, 32'h1);
    storeW(A_SEM3, 4'b0010, 32'h0);
    loadW(A_SEM3);
    checkOutput("sem3_lane1_noclear", DIN, 32'h1);
    storeW(A_SEM3, 4'b0001, 32'h0);
    loadW(A_SEM3);
    checkOutput("sem3_cleared", DIN, 32'h0);
    loadW(32'h4000_0028);
    checkOutput("sem2_independent", DIN, 32'h0);

    // Counter wrap, ID, unmapped offset, ignored upper register-address bits
    storeW(A_CYCLE, 4'hF, 32'hFFFFFFFE);
    idleCycle();
    loadW(A_CYCLE);
    checkOutput("cycle_pre_wrap", DIN, 32'hFFFFFFFF);
    loadW(A_CYCLE);
    checkOutput("cycle_wrap", DIN, 32'h0);
    loadW(A_ID);
    checkOutput("id_value", DIN, 32'h7A3A0001);
    loadW(32'h4000_1000);
    checkOutput("id_alias_upper_bits", DIN, 32'h7A3A0001);
    loadW(32'h4000_0018);
    checkOutput("unmapped_zero", DIN, 32'h0);
    loadW(A_ERRSTAT);
    checkOutput("unmapped_no_err", DIN, 32'hF1);

    // Scratch with lane write
    storeW(A_SCRATCH, 4'hF, 32'h12345678);
    storeW(A_SCRATCH, 4'b1000, 32'hABABABAB);
    loadW(A_SCRATCH);
    checkOutput("scratch_rw", DIN, 32'hAB345678);

    // Reset in the cycle after a load, and a request presented during reset
    RST = 1'b1;
    loadW(A_SCRATCH);
    checkOutput("rst_kills_din", DIN, 32'h0);
    storeW(A_SCRATCH, 4'hF, 32'hFFFFFFFF);
    checkOutput("req_during_rst", DIN, 32'h0);
    RST = 1'b0;
    loadW(A_CYCLE);
    checkOutput("cycle_after_rst", DIN, 32'h0);
    loadW(A_SCRATCH);
    checkOutput("scratch_after_rst", DIN, 32'h0);
    loadW(A_ERRSTAT);
    checkOutput("errstat_after_rst", DIN, 32'h0);
    loadW(32'h100);
    checkOutput("ram_survives_rst", DIN, 32'h11AA3344);
    idleCycle();
    checkOutput("din_final_idle", DIN, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
